// File: rtl/motor_ctrl_multi.sv
// Multi-channel up/down motor controller: each channel runs toward the opposite end-stop,
// stops on limit or abort, waits out a dead-time, and latches a fault on timeout or bad limits.
module motor_ctrl_multi #(
    parameter int N_CH     = 2,
    parameter int MAX_RUN  = 1000,
    parameter int DEAD_CYC = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] activate,
    input  logic [N_CH-1:0] up_limit,
    input  logic [N_CH-1:0] dn_limit,
    input  logic [N_CH-1:0] abort,
    input  logic [N_CH-1:0] fault_clr,
    output logic [N_CH-1:0] motor_up_q,
    output logic [N_CH-1:0] motor_dn_q,
    output logic [N_CH-1:0] fault_q,
    output logic [N_CH-1:0] busy_q,
    output logic            any_fault_q
);
    localparam int CNT_MAX = (MAX_RUN > DEAD_CYC) ? MAX_RUN : DEAD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_RUN - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_UP, S_DN, S_DEAD, S_FAULT} state_t;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_up, r_dn, r_fault, r_busy;
        logic             w_lim;

        // The limit that ends the current move: the end-stop we are driving toward.
        assign w_lim = (r_state == S_DN) ? dn_limit[g] : up_limit[g];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_up    <= 1'b0;
                r_dn    <= 1'b0;
                r_fault <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (up_limit[g] && dn_limit[g]) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                            r_busy  <= 1'b1;
                        end else if (activate[g]) begin
                            r_cnt  <= '0;
                            r_busy <= 1'b1;
                            if (up_limit[g]) begin
                                r_state <= S_DN;
                                r_dn    <= 1'b1;
                            end else begin
                                r_state <= S_UP;
                                r_up    <= 1'b1;
                            end
                        end
                    end
                    S_UP, S_DN: begin
                        if (w_lim || abort[g]) begin
                            r_up  <= 1'b0;
                            r_dn  <= 1'b0;
                            r_cnt <= '0;
                            // Zero dead-time skips DEAD entirely.
                            if (DEAD_CYC == 0) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_DEAD;
                            end
                        end else if (r_cnt == RUN_LAST) begin
                            r_up    <= 1'b0;
                            r_dn    <= 1'b0;
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DEAD: begin
                        if (r_cnt == DEAD_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_FAULT: begin
                        if (fault_clr[g]) begin
                            r_state <= S_IDLE;
                            r_fault <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_up    <= 1'b0;
                        r_dn    <= 1'b0;
                        r_fault <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end

        assign motor_up_q[g] = r_up;
        assign motor_dn_q[g] = r_dn;
        assign fault_q[g]    = r_fault;
        assign busy_q[g]     = r_busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) any_fault_q <= 1'b0;
        else        any_fault_q <= |fault_q;
    end
endmodule

// File: tb/tb_motor_ctrl_multi.sv
// Directed bench: dut A (2 ch, MAX_RUN=32, DEAD_CYC=4), dut B (1 ch, MAX_RUN=16, DEAD_CYC=0).
module tb_motor_ctrl_multi;
    logic       clk = 1'b0;
    logic       a_rst_n, b_rst_n;
    logic [1:0] a_act, a_up_l, a_dn_l, a_abort, a_clr;
    logic [1:0] a_mup, a_mdn, a_flt, a_busy;
    logic       a_any;
    logic       b_act, b_up_l, b_dn_l, b_abort, b_clr;
    logic       b_mup, b_mdn, b_flt, b_busy, b_any;
    int         n_chk = 0, n_fail = 0, both_hits = 0;
    logic       ok;

    always #5 clk = ~clk;

    motor_ctrl_multi #(.N_CH(2), .MAX_RUN(32), .DEAD_CYC(4)) u_a (
        .clk(clk), .rst_n(a_rst_n), .activate(a_act), .up_limit(a_up_l), .dn_limit(a_dn_l),
        .abort(a_abort), .fault_clr(a_clr), .motor_up_q(a_mup), .motor_dn_q(a_mdn),
        .fault_q(a_flt), .busy_q(a_busy), .any_fault_q(a_any));

    motor_ctrl_multi #(.N_CH(1), .MAX_RUN(16), .DEAD_CYC(0)) u_b (
        .clk(clk), .rst_n(b_rst_n), .activate(b_act), .up_limit(b_up_l), .dn_limit(b_dn_l),
        .abort(b_abort), .fault_clr(b_clr), .motor_up_q(b_mup), .motor_dn_q(b_mdn),
        .fault_q(b_flt), .busy_q(b_busy), .any_fault_q(b_any));

    always @(negedge clk) if (|(a_mup & a_mdn) || (b_mup & b_mdn)) both_hits++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_act = '0; a_up_l = '0; a_dn_l = '0; a_abort = '0; a_clr = '0;
        b_act = 1'b0; b_up_l = 1'b0; b_dn_l = 1'b0; b_abort = 1'b0; b_clr = 1'b0;
        #12;
        chk("rst_a_outs", {a_mup, a_mdn, a_flt, a_busy, 7'd0, a_any}, 32'd0);
        chk("rst_b_outs", {b_mup, b_mdn, b_flt, b_busy, b_any}, 32'd0);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();

        // Ch0 up run for 20 cycles, stop on up_limit, 4 dead cycles.
        a_act = 2'b01;
        tick();
        a_act = 2'b00;
        chk("t1_start_up", {a_mup, a_mdn, a_busy}, {2'b01, 2'b00, 2'b01});
        ok = 1'b1;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (a_mup !== 2'b01 || a_mdn !== 2'b00) ok = 1'b0;
        end
        chk("t1_up_held_20", {31'd0, ok}, 32'd1);
        a_up_l = 2'b01;
        tick();
        chk("t1_stop", {a_mup, a_busy}, {2'b00, 2'b01});
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_busy !== 2'b01) ok = 1'b0;
        end
        chk("t1_dead_busy", {31'd0, ok}, 32'd1);
        tick();
        chk("t1_idle", {a_busy, a_mup, a_mdn, a_flt}, 8'd0);

        // Ch1 starts at the top, runs down, dn_limit at cycle 10.
        a_up_l = 2'b11;
        a_act = 2'b10;
        tick();
        a_act = 2'b00; a_up_l = 2'b01;
        chk("t2_start_dn", {a_mup, a_mdn, a_busy}, {2'b00, 2'b10, 2'b10});
        for (int i = 0; i < 9; i++) tick();
        chk("t2_dn_held", {30'd0, a_mdn}, 32'd2);
        a_dn_l = 2'b10;
        tick();
        chk("t2_stop", {a_mdn, a_busy}, {2'b00, 2'b10});
        for (int i = 0; i < 3; i++) tick();
        chk("t2_dead_busy", {30'd0, a_busy}, 32'd2);
        tick();
        chk("t2_idle", {30'd0, a_busy}, 32'd0);
        a_dn_l = 2'b00; a_up_l = 2'b00;

        // Ch0 inconsistent limits -> FAULT, no motor drive.
        a_up_l = 2'b01; a_dn_l = 2'b01; a_act = 2'b01;
        tick();
        chk("t3_fault", {a_flt, a_busy, a_mup, a_mdn, 7'd0, a_any}, {2'b01, 2'b01, 2'b00, 2'b00, 8'd0});
        a_act = 2'b00; a_up_l = 2'b00; a_dn_l = 2'b00;
        tick();
        chk("t3_any_fault", {a_mup, a_mdn, 7'd0, a_any}, {4'd0, 8'd1});
        a_clr = 2'b01;
        tick();
        a_clr = 2'b00;
        chk("t3_clear", {a_flt, a_busy}, 4'd0);

        // Ch0 abort at cycle 5 with activate held; restart goes DN due to up_limit.
        a_act = 2'b01;
        tick();
        chk("t4_start_up", {30'd0, a_mup}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        a_abort = 2'b01;
        tick();
        a_abort = 2'b00; a_up_l = 2'b01;
        chk("t4_abort_stop", {a_mup, a_mdn, a_busy}, {4'd0, 2'b01});
        for (int i = 0; i < 3; i++) tick();
        chk("t4_dead_busy", {a_mup, a_mdn, a_busy}, {4'd0, 2'b01});
        tick();
        chk("t4_idle", {a_mup, a_mdn, a_busy}, 6'd0);
        tick();
        chk("t4_restart_dn", {a_mup, a_mdn, a_busy}, {2'b00, 2'b01, 2'b01});
        a_act = 2'b00;
        tick();
        chk("t4_dn_ignores_up", {30'd0, a_mdn}, 32'd1);
        a_dn_l = 2'b01; a_up_l = 2'b00;
        tick();
        chk("t4_dn_stop", {30'd0, a_mdn}, 32'd0);
        a_dn_l = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_final_idle", {30'd0, a_busy}, 32'd0);

        // Dut B timeout after exactly 16 cycles.
        b_act = 1'b1;
        tick();
        b_act = 1'b0;
        ok = b_mup;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (b_mup !== 1'b1) ok = 1'b0;
        end
        chk("t5_up_16", {31'd0, ok}, 32'd1);
        tick();
        chk("t5_timeout", {b_mup, b_flt, b_busy, b_any}, 4'b0110);
        b_act = 1'b1;
        tick();
        chk("t5_any_lag", {b_mup, b_flt, b_any}, 3'b011);
        tick();
        chk("t5_act_ignored", {b_mup, b_mdn, b_flt}, 3'b001);
        b_act = 1'b0; b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        chk("t5_clear", {b_flt, b_busy, b_any}, 3'b001);
        tick();
        chk("t5_any_drop", {31'd0, b_any}, 32'd0);

        // Dut B zero dead-time, then async reset mid-run.
        b_act = 1'b1;
        tick();
        b_act = 1'b0;
        tick(); tick();
        b_up_l = 1'b1;
        tick();
        chk("t6_nodead", {b_mup, b_busy}, 2'b00);
        b_up_l = 1'b0; b_act = 1'b1;
        tick();
        b_act = 1'b0;
        tick();
        chk("t6_running", {b_mup, b_busy}, 2'b11);
        b_rst_n = 1'b0;
        #1;
        chk("t6_async_rst", {b_mup, b_mdn, b_flt, b_busy, b_any}, 5'd0);
        b_rst_n = 1'b1;
        tick();

        chk("no_both_motor", both_hits, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/motor_ctrl_multi.md
# motor_ctrl_multi

Parametrised multi-channel motor controller, next generation of the single-channel up/down motor FSM. Each of N_CH independent channels drives a motor toward the opposite end-stop on `activate`, stops on the limit switch, enforces a post-stop dead-time before the next move, and latches a fault on run timeout or inconsistent limits. It sits between the user-command logic and the motor driver pins. All outputs are registered.

## Interface
- N_CH, 2, number of independent motor channels (≥1)
- MAX_RUN, 1000, maximum cycles a motor may run before a timeout fault (≥2)
- DEAD_CYC, 4, idle cycles enforced after every stop before a new activate is accepted (≥0)
- CNT_W, derived = clog2(max(MAX_RUN, DEAD_CYC)+1), per-channel counter width
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- activate  input  N_CH  per-channel move request, sampled only in IDLE
- up_limit  input  N_CH  upper end-stop switch, active high
- dn_limit  input  N_CH  lower end-stop switch, active high
- abort  input  N_CH  stop the running motor now, enter dead-time
- fault_clr  input  N_CH  clear a latched fault
- motor_up_q  output  N_CH  drive motor up
- motor_dn_q  output  N_CH  drive motor down
- fault_q  output  N_CH  channel in FAULT
- busy_q  output  N_CH  channel not in IDLE
- any_fault_q  output  1  OR of all fault_q, registered

## Operation
- Channels are fully independent copies; channel i uses only bit i of every vector.
- Per-channel states: IDLE, UP, DN, DEAD, FAULT; counter cnt[CNT_W-1:0].
- IDLE: up_limit & dn_limit -> FAULT (takes priority over activate). Else activate & up_limit -> DN, motor_dn=1, cnt=0. Else activate -> UP, motor_up=1, cnt=0. Else stay.
- UP, priority order: up_limit -> motor_up=0, go DEAD; else abort -> motor_up=0, DEAD; else cnt==MAX_RUN-1 -> motor_up=0, FAULT; else cnt+1.
- DN: same as UP with dn_limit and motor_dn.
- Entering DEAD loads cnt=0; DEAD -> IDLE when cnt==DEAD_CYC-1, else cnt+1. DEAD_CYC=0: transitions that would enter DEAD go directly to IDLE.
- FAULT: both motor outputs 0; fault_clr -> IDLE (no dead-time). activate ignored.
- activate, abort, fault_clr are level-sampled; holding activate high in IDLE restarts a move each time IDLE is reached.
- Invariant: motor_up_q[i] & motor_dn_q[i] is never 1.
- busy_q = (next state != IDLE), fault_q = (next state == FAULT), registered with the state.

## Timing
- Reset: all states IDLE, cnt=0, motor_up_q=motor_dn_q=fault_q=busy_q=0, any_fault_q=0.
- activate high at edge k in IDLE -> motor_*_q and busy_q high after edge k.
- Limit/abort high at edge k while running -> motor_*_q low after edge k; busy_q stays high for DEAD_CYC more cycles, then low.
- Timeout: with no limit/abort, motor output high for exactly MAX_RUN cycles; at the edge it falls, fault_q rises.
- any_fault_q lags fault_q by one cycle.
- fault_clr at edge k -> fault_q and busy_q low after edge k; activate accepted from edge k+1.
- Reset asserted mid-move: outputs drop asynchronously, no dead-time.

## Test plan
- Ch0 up_limit=0, pulse activate 1 cycle; raise up_limit 20 cycles later -> motor_up_q[0] high 20 cycles, then low; busy_q[0] low exactly 4 cycles later; ch1 outputs stay 0.
- Ch1 at up_limit=1, activate -> motor_dn_q[1]=1; dn_limit at cycle 10 -> stop, DEAD 4 cycles, IDLE.
- MAX_RUN=16, activate with limits held 0 -> motor_up_q high 16 cycles, fault_q=1 same edge it falls, any_fault_q one cycle later; activate ignored; fault_clr -> IDLE.
- up_limit=dn_limit=1 in IDLE with activate -> FAULT, no motor output ever asserted.
- abort at cycle 5 of a run, activate held high -> stop, 4 dead cycles, then new move in DN/UP per limit; check no cycle with both motor outputs high.
- DEAD_CYC=0 build: limit reached -> busy_q low the following cycle; rst_n low mid-run -> all outputs 0 immediately.
